dft_index_seq: RTL and testbench
================================

# dft_index_seq

Datapath sequencer that executes the commands issued by the DFT control FSM. It generates source-read and cache-write addresses during the load phase, then the n/k/twiddle index stream for the multiply-accumulate in the compute phase. It reports progress back to the FSM through `data_to_cache_loaded` and `calc_end`.

## Interface

Parameters:
- `ADDR_W`, 12: width of sample count, addresses and indices.

Ports:
- `clk` in 1: system clock.
- `nrst` in 1: reset. Asynchronous and active-low.
- `ce` in 1: clock enable. When low, all state and outputs freeze.
- `sample_num` in ADDR_W: transform length N. Value 0 means 2^ADDR_W.
- `load_nCompute` in 1: 1 selects the load phase, 0 selects the compute phase.
- `clear` in 1: synchronous active-low clear of counters and flags.
- `count_n_en` in 1: advance the n counter.
- `count_k_en` in 1: in the compute phase, must be high together with `count_n_en` to advance.
- `src_rd_addr` out ADDR_W: source sample RAM read address. The RAM has 1-cycle read latency.
- `cache_wr_en` out 1: cache write strobe.
- `cache_wr_addr` out ADDR_W: cache write address.
- `n_idx` out ADDR_W: compute-phase sample index.
- `k_idx` out ADDR_W: compute-phase bin index.
- `tw_idx` out ADDR_W: twiddle index, equal to (n·k) mod N.
- `mac_valid` out 1: `n_idx`, `k_idx` and `tw_idx` are valid this cycle.
- `mac_first` out 1: valid beat with n = 0.
- `mac_last` out 1: valid beat with n = N−1.
- `data_to_cache_loaded` out 1: level flag, load complete.
- `calc_end` out 1: level flag, all bins issued.

## Operation

General rules:
- All outputs reset to 0.
- Every rule below applies only on cycles with `ce` = 1.
- `clear` = 0 zeroes every counter, the pipeline and both flags on the next edge. It overrides all other inputs.
- N is latched into `n_len` on each cycle where `clear` = 0. Changes to `sample_num` outside those cycles are ignored.

Internal states (derived, 3-bit enum): IDLE, LOAD, LOADED, COMPUTE, DONE.
- IDLE → LOAD: `load_nCompute` = 1, `clear` = 1, `count_n_en` = 1.
- LOAD → LOADED: after the read with n = N−1 has been issued.
- LOADED → COMPUTE: `clear` = 0 followed by `load_nCompute` = 0.
- COMPUTE → DONE: after the beat with k = K_last and n = N−1.
- Any state → IDLE: `clear` = 0 while `load_nCompute` = 1.

Load phase:
- Each cycle with `count_n_en` = 1: `src_rd_addr` ← n, then n increments.
- One cycle later: `cache_wr_en` = 1 and `cache_wr_addr` = the previous `src_rd_addr`.
- `data_to_cache_loaded` rises on the cycle after the last cache write.
- Once n reaches N, further enables are ignored.

Compute phase:
- A beat occurs each cycle where `count_n_en` & `count_k_en` = 1. The outputs are registered.
- Loop order: n is the inner loop over 0..N−1; k is the outer loop over 0..K_last, where K_last = N−1.
- Twiddle index is computed incrementally with no multiplier:
  - tw resets to 0 when n wraps.
  - Otherwise tw ← tw + k, minus N when the sum is ≥ N.
  - The sum is ADDR_W+1 bits wide.
- `calc_end` rises on the cycle after the final beat and holds until `clear` = 0.
- Enables in DONE are ignored.

## Timing

- Enable to `src_rd_addr` / `mac_*`: 1 cycle.
- Enable to `cache_wr_en`: 2 cycles.
- Load of N samples: `data_to_cache_loaded` asserts N+2 cycles after the first enable, given continuous enables.
- Compute: `calc_end` asserts N·(K_last+1)+1 cycles after the first beat.
- `ce` = 0 mid-pipeline: a pending cache write is held, not dropped.
- Async reset mid-operation returns to IDLE with all outputs 0.

## Configuration

- `DFT_HALF_SPECTRUM_EN` defined: K_last = floor(N/2), for real input. `calc_end` follows the beat with k = floor(N/2).
- `DFT_HALF_SPECTRUM_EN` undefined: K_last = N−1.

## Structure

- Package `dft_pkg` holds:
  - `ADDR_W` default constant.
  - `seq_state_t` enum.
  - `DFT_LEN_MAX` = 2^ADDR_W.
- Sub-module `dft_tw_acc` holds the modular twiddle accumulator, with inputs k, n_wrap, step and N.

## Test plan

- Load, N = 8, continuous enables → `src_rd_addr` 0..7; `cache_wr_addr` 0..7, one cycle later; `data_to_cache_loaded` = 1 at cycle 10.
- Compute, N = 4 → `tw_idx` sequence per bin:
  - k = 0: 0,0,0,0
  - k = 1: 0,1,2,3
  - k = 2: 0,2,0,2
  - k = 3: 0,3,2,1
  - `calc_end` rises after beat 16.
- Toggle `ce` low for 3 cycles during load, N = 8 → no lost or duplicated cache writes; addresses stay in order.
- Drive `clear` = 0 at k = 2, n = 1, N = 8 → all indices and flags are 0 next cycle; compute restarts at k = 0.
- Assert `nrst` low mid-load → all outputs 0 immediately; state IDLE.
- With `DFT_HALF_SPECTRUM_EN` defined, N = 8 → k runs 0..4; `calc_end` after 40 beats. With `sample_num` = 0 → N = 4096.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared types and constants for the DFT index sequencer.
package dft_pkg;

  // Default width of sample count, addresses and indices.
  localparam int ADDR_W_DEFAULT = 12;

  // Largest transform length; sample_num == 0 selects it.
  localparam int DFT_LEN_MAX = 2 ** ADDR_W_DEFAULT;

  // Sequencer phase, derived from the command inputs.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_LOADED  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/dft_tw_acc.sv
// Modular twiddle accumulator: tracks (n*k) mod N without a multiplier.
// Adds k on every step and subtracts N when the sum reaches N; a step that
// wraps n back to 0 restarts the accumulator at 0.
module dft_tw_acc
  import dft_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ce_i,
  input  logic              clear_ni,   // synchronous, active-low
  input  logic              step_i,
  input  logic              n_wrap_i,
  input  logic [ADDR_W-1:0] k_i,
  input  logic [ADDR_W:0]   n_len_i,
  output logic [ADDR_W-1:0] tw_o
);

  logic [ADDR_W-1:0] tw_q, tw_d;
  logic [ADDR_W:0]   sum;

  // Next accumulator value: one extra bit keeps tw + k from overflowing.
  always_comb begin
    sum  = {1'b0, tw_q} + {1'b0, k_i};
    tw_d = tw_q;
    if (!clear_ni) begin
      tw_d = '0;
    end else if (step_i) begin
      if (n_wrap_i) begin
        tw_d = '0;
      end else if (sum >= n_len_i) begin
        tw_d = ADDR_W'(sum - n_len_i);
      end else begin
        tw_d = sum[ADDR_W-1:0];
      end
    end
  end

  // Accumulator register, frozen while ce is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tw_q <= '0;
    end else if (ce_i) begin
      tw_q <= tw_d;
    end
  end

  assign tw_o = tw_q;

endmodule

// File: rtl/dft_index_seq.sv
// DFT datapath sequencer: load-phase read/write addressing, then the
// n/k/twiddle index stream for the MAC in the compute phase.
// Build option: define DFT_HALF_SPECTRUM_EN to stop at k = floor(N/2)
// (real input); otherwise k runs to N-1.
//
// Output qualification: there is no backpressure. cache_wr_en and mac_valid
// mark a beat that the consumer takes on the next rising edge with ce = 1;
// while ce is low every output holds, so a held beat is taken exactly once.
module dft_index_seq
  import dft_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] sample_num,
  input  logic              load_nCompute,
  input  logic              clear,
  input  logic              count_n_en,
  input  logic              count_k_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  output logic              cache_wr_en,
  output logic [ADDR_W-1:0] cache_wr_addr,
  output logic [ADDR_W-1:0] n_idx,
  output logic [ADDR_W-1:0] k_idx,
  output logic [ADDR_W-1:0] tw_idx,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic              data_to_cache_loaded,
  output logic              calc_end
);

  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LEN_MAX = ONE << ADDR_W;

  seq_state_t state_q, state_d;

  // Counters are one bit wider so N = 2^ADDR_W is representable.
  logic [ADDR_W:0]   n_len_q, n_len_d, n_q, n_d, k_q, k_d;
  logic [ADDR_W:0]   len_sel, n_last, k_last;
  logic [ADDR_W-1:0] src_rd_addr_q, src_rd_addr_d, cache_wr_addr_q, cache_wr_addr_d;
  logic [ADDR_W-1:0] n_idx_q, n_idx_d, k_idx_q, k_idx_d, tw_idx_q, tw_idx_d;
  logic              rd_v_q, rd_v_d, cache_wr_en_q, cache_wr_en_d;
  logic              mac_valid_q, mac_valid_d, mac_first_q, mac_first_d;
  logic              mac_last_q, mac_last_d, mac_klast_q, mac_klast_d;
  logic              loaded_q, loaded_d, calc_end_q, calc_end_d;
  logic              rd_fire, beat_fire, n_wrap, final_beat;
  logic [ADDR_W-1:0] tw_cur;

  assign len_sel = (sample_num == '0) ? LEN_MAX : {1'b0, sample_num};
  assign n_last  = n_len_q - ONE;
`ifdef DFT_HALF_SPECTRUM_EN
  assign k_last  = n_len_q >> 1;
`else
  assign k_last  = n_len_q - ONE;
`endif

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  // Next state: clear wins; with load selected it aborts to IDLE, otherwise
  // a loaded cache (re)starts the compute sweep from k = 0.
  always_comb begin
    state_d = state_q;
    if (!clear) begin
      if (load_nCompute || state_q == ST_IDLE || state_q == ST_LOAD) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_COMPUTE;
      end
    end else begin
      case (state_q)
        ST_IDLE:    if (rd_fire) state_d = n_wrap ? ST_LOADED : ST_LOAD;
        ST_LOAD:    if (rd_fire && n_wrap) state_d = ST_LOADED;
        ST_COMPUTE: if (final_beat) state_d = ST_DONE;
        default:    state_d = state_q;
      endcase
    end
  end

  // State decode: which kind of beat the current inputs launch.
  always_comb begin
    n_wrap     = (n_q == n_last);
    rd_fire    = clear && load_nCompute && count_n_en && (n_q < n_len_q) &&
                 (state_q == ST_IDLE || state_q == ST_LOAD);
    beat_fire  = clear && (state_q == ST_COMPUTE) && count_n_en && count_k_en;
    final_beat = beat_fire && n_wrap && (k_q == k_last);
  end

  // Datapath next values: counters, read->write pipeline, MAC beat, flags.
  always_comb begin
    n_len_d         = clear ? n_len_q : len_sel;
    n_d             = n_q;
    k_d             = k_q;
    src_rd_addr_d   = src_rd_addr_q;
    rd_v_d          = 1'b0;
    cache_wr_en_d   = 1'b0;
    cache_wr_addr_d = cache_wr_addr_q;
    n_idx_d         = n_idx_q;
    k_idx_d         = k_idx_q;
    tw_idx_d        = tw_idx_q;
    mac_valid_d     = 1'b0;
    mac_first_d     = 1'b0;
    mac_last_d      = 1'b0;
    mac_klast_d     = 1'b0;
    loaded_d        = loaded_q;
    calc_end_d      = calc_end_q;
    if (!clear) begin
      n_d             = '0;
      k_d             = '0;
      src_rd_addr_d   = '0;
      cache_wr_addr_d = '0;
      n_idx_d         = '0;
      k_idx_d         = '0;
      tw_idx_d        = '0;
      loaded_d        = 1'b0;
      calc_end_d      = 1'b0;
    end else begin
      if (rd_fire) begin
        src_rd_addr_d = n_q[ADDR_W-1:0];
        rd_v_d        = 1'b1;
        n_d           = n_q + ONE;
      end
      // Read data appears one cycle after the address: write it then.
      cache_wr_en_d = rd_v_q;
      if (rd_v_q) cache_wr_addr_d = src_rd_addr_q;
      if (cache_wr_en_q && ({1'b0, cache_wr_addr_q} == n_last)) loaded_d = 1'b1;
      if (beat_fire) begin
        n_idx_d     = n_q[ADDR_W-1:0];
        k_idx_d     = k_q[ADDR_W-1:0];
        tw_idx_d    = tw_cur;
        mac_valid_d = 1'b1;
        mac_first_d = (n_q == '0);
        mac_last_d  = n_wrap;
        mac_klast_d = (k_q == k_last);
        n_d         = n_wrap ? '0 : n_q + ONE;
        if (n_wrap) k_d = k_q + ONE;
      end
      if (mac_valid_q && mac_last_q && mac_klast_q) calc_end_d = 1'b1;
    end
  end

  // Datapath registers, frozen while ce is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      n_len_q         <= LEN_MAX;
      n_q             <= '0;
      k_q             <= '0;
      src_rd_addr_q   <= '0;
      rd_v_q          <= 1'b0;
      cache_wr_en_q   <= 1'b0;
      cache_wr_addr_q <= '0;
      n_idx_q         <= '0;
      k_idx_q         <= '0;
      tw_idx_q        <= '0;
      mac_valid_q     <= 1'b0;
      mac_first_q     <= 1'b0;
      mac_last_q      <= 1'b0;
      mac_klast_q     <= 1'b0;
      loaded_q        <= 1'b0;
      calc_end_q      <= 1'b0;
    end else if (ce) begin
      n_len_q         <= n_len_d;
      n_q             <= n_d;
      k_q             <= k_d;
      src_rd_addr_q   <= src_rd_addr_d;
      rd_v_q          <= rd_v_d;
      cache_wr_en_q   <= cache_wr_en_d;
      cache_wr_addr_q <= cache_wr_addr_d;
      n_idx_q         <= n_idx_d;
      k_idx_q         <= k_idx_d;
      tw_idx_q        <= tw_idx_d;
      mac_valid_q     <= mac_valid_d;
      mac_first_q     <= mac_first_d;
      mac_last_q      <= mac_last_d;
      mac_klast_q     <= mac_klast_d;
      loaded_q        <= loaded_d;
      calc_end_q      <= calc_end_d;
    end
  end

  dft_tw_acc #(.ADDR_W(ADDR_W)) u_tw_acc (
    .clk      (clk),
    .nrst     (nrst),
    .ce_i     (ce),
    .clear_ni (clear),
    .step_i   (beat_fire),
    .n_wrap_i (n_wrap),
    .k_i      (k_q[ADDR_W-1:0]),
    .n_len_i  (n_len_q),
    .tw_o     (tw_cur)
  );

  assign src_rd_addr          = src_rd_addr_q;
  assign cache_wr_en          = cache_wr_en_q;
  assign cache_wr_addr        = cache_wr_addr_q;
  assign n_idx                = n_idx_q;
  assign k_idx                = k_idx_q;
  assign tw_idx               = tw_idx_q;
  assign mac_valid            = mac_valid_q;
  assign mac_first            = mac_first_q;
  assign mac_last             = mac_last_q;
  assign data_to_cache_loaded = loaded_q;
  assign calc_end             = calc_end_q;

endmodule

// File: tb/tb_dft_index_seq.sv
// Testbench for dft_index_seq: directed load/compute/clear/ce/reset scenarios
// with a scoreboard on the cache-write and MAC-beat streams.
module tb_dft_index_seq;

  localparam int W  = 12;
  localparam int MW = 3 * W + 2;

  logic          clk, nrst, ce, load_nCompute, clear, count_n_en, count_k_en;
  logic [W-1:0]  sample_num;
  logic [W-1:0]  src_rd_addr, cache_wr_addr, n_idx, k_idx, tw_idx;
  logic          cache_wr_en, mac_valid, mac_first, mac_last;
  logic          data_to_cache_loaded, calc_end;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]  exp_wr_q[$];
  logic [MW-1:0] exp_mac_q[$];
  logic [W-1:0]  mon_wr_e;
  logic [MW-1:0] mon_mac_e;

  // Hand-computed (n*k) mod 4, listed bin by bin.
  int tw4[16] = '{0, 0, 0, 0,  0, 1, 2, 3,  0, 2, 0, 2,  0, 3, 2, 1};

  dft_index_seq #(.ADDR_W(W)) dut (
    .clk                  (clk),
    .nrst                 (nrst),
    .ce                   (ce),
    .sample_num           (sample_num),
    .load_nCompute        (load_nCompute),
    .clear                (clear),
    .count_n_en           (count_n_en),
    .count_k_en           (count_k_en),
    .src_rd_addr          (src_rd_addr),
    .cache_wr_en          (cache_wr_en),
    .cache_wr_addr        (cache_wr_addr),
    .n_idx                (n_idx),
    .k_idx                (k_idx),
    .tw_idx               (tw_idx),
    .mac_valid            (mac_valid),
    .mac_first            (mac_first),
    .mac_last             (mac_last),
    .data_to_cache_loaded (data_to_cache_loaded),
    .calc_end             (calc_end)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int klast(input int len);
`ifdef DFT_HALF_SPECTRUM_EN
    return len / 2;
`else
    return len - 1;
`endif
  endfunction

  function automatic logic [MW-1:0] mac_word(input int n, input int k, input int len, input int tw);
    logic f, l;
    f = (n == 0);
    l = (n == len - 1);
    return {f, l, W'(n), W'(k), W'(tw)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input int s, input logic ld);
    count_n_en    = 1'b0;
    count_k_en    = 1'b0;
    clear         = 1'b0;
    load_nCompute = ld;
    sample_num    = W'(s);
    step();
    clear = 1'b1;
  endtask

  task automatic wait_loaded();
    for (int i = 0; i < 8; i++) begin
      if (data_to_cache_loaded) break;
      step();
    end
    chk("data_to_cache_loaded", 64'(data_to_cache_loaded), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_wr_q.size() == 0 && exp_mac_q.size() == 0) break;
      step();
    end
    chk("scoreboard_drained", 64'(exp_wr_q.size() + exp_mac_q.size()), 64'd0);
  endtask

  task automatic load_n(input int s, input int len);
    do_clear(s, 1'b1);
    count_n_en = 1'b1;
    for (int i = 0; i < len; i++) begin
      exp_wr_q.push_back(W'(i));
      step();
      chk("src_rd_addr", 64'(src_rd_addr), 64'(i));
    end
    count_n_en = 1'b0;
    wait_loaded();
    drain();
  endtask

  task automatic go_compute();
    clear         = 1'b0;
    load_nCompute = 1'b0;
    step();
    clear = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (nrst && ce) begin
      if (cache_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL cache_wr_unexpected: got write addr 0x%0h, expected none at %0t",
                   cache_wr_addr, $time);
        end else begin
          mon_wr_e = exp_wr_q.pop_front();
          chk("cache_wr_addr", 64'(cache_wr_addr), 64'(mon_wr_e));
        end
      end
      if (mac_valid) begin
        if (exp_mac_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL mac_unexpected: got n=%0d k=%0d tw=%0d, expected none at %0t",
                   n_idx, k_idx, tw_idx, $time);
        end else begin
          mon_mac_e = exp_mac_q.pop_front();
          chk("mac_beat{first,last,n,k,tw}",
              64'({mac_first, mac_last, n_idx, k_idx, tw_idx}), 64'(mon_mac_e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int nb;
    nrst          = 1'b0;
    ce            = 1'b1;
    clear         = 1'b1;
    load_nCompute = 1'b0;
    count_n_en    = 1'b0;
    count_k_en    = 1'b0;
    sample_num    = '0;
    repeat (3) step();

    // Reset state.
    chk("reset_addr_outputs", 64'({src_rd_addr, cache_wr_addr}), 64'd0);
    chk("reset_idx_outputs", 64'({n_idx, k_idx, tw_idx}), 64'd0);
    chk("reset_flags", 64'({cache_wr_en, mac_valid, mac_first, mac_last,
                            data_to_cache_loaded, calc_end}), 64'd0);
    nrst = 1'b1;
    step();

    // Load N = 8 with continuous enables, cycle-exact flag timing.
    do_clear(8, 1'b1);
    for (int i = 0; i < 8; i++) exp_wr_q.push_back(W'(i));
    count_n_en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c <= 8) chk("load8_src_rd_addr", 64'(src_rd_addr), 64'(c - 1));
      if (c == 1) chk("load8_wr_latency", 64'(cache_wr_en), 64'd0);
      if (c == 9) chk("load8_loaded_early", 64'(data_to_cache_loaded), 64'd0);
      if (c == 10) chk("load8_loaded_cycle10", 64'(data_to_cache_loaded), 64'd1);
    end
    count_n_en = 1'b0;
    drain();

    // Compute N = 4 against the hand table.
    load_n(4, 4);
    go_compute();
    chk("compute_clears_loaded", 64'(data_to_cache_loaded), 64'd0);
    count_n_en = 1'b1;
    count_k_en = 1'b1;
    nb = 4 * (klast(4) + 1);
    for (int b = 0; b < nb; b++) begin
      exp_mac_q.push_back(mac_word(b % 4, b / 4, 4, tw4[b]));
      step();
    end
    chk("n4_calc_end_early", 64'(calc_end), 64'd0);
    step();
    chk("n4_calc_end", 64'(calc_end), 64'd1);
    repeat (2) step();
    count_n_en = 1'b0;
    count_k_en = 1'b0;
    drain();
    chk("n4_calc_end_holds", 64'(calc_end), 64'd1);

    // ce low for 3 cycles in the middle of a load.
    do_clear(8, 1'b1);
    for (int i = 0; i < 8; i++) exp_wr_q.push_back(W'(i));
    count_n_en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      ce = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      step();
    end
    ce         = 1'b1;
    count_n_en = 1'b0;
    wait_loaded();
    drain();

    // Clear at k = 2, n = 1 with N = 8, then restart from k = 0.
    load_n(8, 8);
    go_compute();
    count_n_en = 1'b1;
    count_k_en = 1'b1;
    for (int b = 0; b < 17; b++) begin
      exp_mac_q.push_back(mac_word(b % 8, b / 8, 8, ((b % 8) * (b / 8)) % 8));
      step();
    end
    clear         = 1'b0;
    load_nCompute = 1'b0;
    step();
    chk("clr_idx", 64'({n_idx, k_idx, tw_idx}), 64'd0);
    chk("clr_flags", 64'({mac_valid, mac_first, mac_last, calc_end, data_to_cache_loaded}), 64'd0);
    clear = 1'b1;
    for (int b = 0; b < 10; b++) begin
      exp_mac_q.push_back(mac_word(b % 8, b / 8, 8, ((b % 8) * (b / 8)) % 8));
      step();
    end
    count_n_en = 1'b0;
    count_k_en = 1'b0;
    drain();

    // Async reset in the middle of a load.
    do_clear(8, 1'b1);
    count_n_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_wr_q.push_back(W'(i));
      step();
    end
    #1;
    nrst = 1'b0;
    #1;
    exp_wr_q.delete();
    chk("arst_addrs", 64'({src_rd_addr, cache_wr_addr}), 64'd0);
    chk("arst_flags", 64'({cache_wr_en, mac_valid, data_to_cache_loaded, calc_end}), 64'd0);
    chk("arst_state_idle", 64'(dut.state_q), 64'd0);
    count_n_en = 1'b0;
    repeat (2) step();
    nrst = 1'b1;
    step();

    // Odd length after reset, then sample_num = 0 meaning 4096.
    load_n(3, 3);
    load_n(0, 4096);
    chk("n4096_last_write_addr", 64'(cache_wr_addr), 64'd4095);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
